// File: rtl/nx_ram_1rw_indirect_access_v3_pkg.sv
// Shared types for the indirect RAM access controller family.
// Holds command opcodes, status codes, FSM states and the data-word helper.
package nx_mem_typePKG_v3;

  typedef enum logic [3:0] {
    OP_NOP     = 4'd0,
    OP_READ    = 4'd1,
    OP_WRITE   = 4'd2,
    OP_ENABLE  = 4'd3,
    OP_DISABLE = 4'd4,
    OP_FILL    = 4'd5
  } cmnd_op_e;

  typedef enum logic [2:0] {
    STAT_OK       = 3'd0,
    STAT_BUSY     = 3'd1,
    STAT_ADDR_ERR = 3'd2,
    STAT_OP_ERR   = 3'd3
  } stat_code_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RD_WAIT,
    ST_FILL
  } ram_state_e;

  function automatic int unsigned datawords(input int unsigned width);
    return (width + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/nx_ram_1rw_indirect_access_v3_rd_lat_pipe.sv
// Valid shift register matching the RAM macro read latency.
// capture is high in the cycle the issued read's data is on ram_dout.
module nx_ram_rd_lat_pipe #(
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic issue,
  output logic capture
);

  logic [RD_LATENCY-1:0] vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= issue;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  assign capture = vld[RD_LATENCY-1];

endmodule

// File: rtl/nx_ram_1rw_indirect_access_v3.sv
// Indirect-access controller for an external 1RW RAM macro: hw client has
// priority, software issues read/write/fill commands through one register.
module nx_ram_1rw_indirect_access_v3
  import nx_mem_typePKG_v3::*;
#(
  parameter int unsigned N_DATA_BITS     = 38,
  parameter int unsigned N_ENTRIES       = 16384,
  parameter int unsigned N_REG_ADDR_BITS = 11,
  parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS = 11'h1B8,
  parameter int unsigned RD_LATENCY      = 1,
  parameter int unsigned STARVE_LIMIT    = 15,
  parameter logic [N_DATA_BITS-1:0] RESET_DATA = '0,
  localparam int unsigned N_ADDR_BITS    = $clog2(N_ENTRIES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_stb,
  input  logic [N_REG_ADDR_BITS-1:0] reg_addr,
  input  logic [3:0]                 cmnd_op,
  input  logic [N_ADDR_BITS:0]       cmnd_addr,
  input  logic [N_DATA_BITS-1:0]     wr_dat,
  output logic [2:0]                 stat_code,
  output logic [4:0]                 stat_datawords,
  output logic [N_ADDR_BITS-1:0]     stat_addr,
  output logic [N_DATA_BITS-1:0]     rd_dat,
  input  logic                       hw_cs,
  input  logic                       hw_we,
  input  logic [N_ADDR_BITS-1:0]     hw_add,
  input  logic [N_DATA_BITS-1:0]     hw_bwe,
  input  logic [N_DATA_BITS-1:0]     hw_din,
  output logic [N_DATA_BITS-1:0]     hw_dout,
  output logic                       hw_yield,
  output logic                       ram_cs,
  output logic                       ram_we,
  output logic [N_ADDR_BITS-1:0]     ram_add,
  output logic [N_DATA_BITS-1:0]     ram_bwe,
  output logic [N_DATA_BITS-1:0]     ram_din,
  input  logic [N_DATA_BITS-1:0]     ram_dout
);

  localparam logic [N_ADDR_BITS:0]   ENTRIES_X = (N_ADDR_BITS+1)'(N_ENTRIES);
  localparam logic [N_ADDR_BITS-1:0] LAST_ADDR = N_ADDR_BITS'(N_ENTRIES - 1);
  localparam logic [7:0]             LIMIT     = 8'(STARVE_LIMIT);

  ram_state_e                 state, state_nxt;
  stat_code_e                 stat_q, stat_nxt;
  logic [N_ADDR_BITS-1:0]     sw_addr, addr_nxt;
  logic [N_DATA_BITS-1:0]     sw_data, data_nxt;
  logic                       sw_we, we_nxt;
  logic                       enable, en_nxt;
  logic [7:0]                 starve, starve_nxt;
  logic                       sw_cs, issue, capture, cmd_hit, addr_bad;

  assign sw_cs    = (state == ST_ACCESS) || (state == ST_FILL);
  assign issue    = sw_cs && !hw_cs;
  assign cmd_hit  = wr_stb && (reg_addr == CMND_ADDRESS) && (state == ST_IDLE);
  assign addr_bad = cmnd_addr >= ENTRIES_X;

  nx_ram_rd_lat_pipe #(.RD_LATENCY(RD_LATENCY)) u_rd_lat_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .issue   (issue && !sw_we),
    .capture (capture)
  );

  // Software request registers are never touched while hw_cs blocks them.
  always_comb begin
    if (hw_cs) begin
      ram_we  = hw_we;
      ram_add = hw_add;
      ram_bwe = hw_bwe;
      ram_din = hw_din;
    end else begin
      ram_we  = sw_cs && sw_we;
      ram_add = sw_addr;
      ram_bwe = '1;
      ram_din = sw_data;
    end
  end

  assign ram_cs         = hw_cs || sw_cs;
  assign hw_dout        = enable ? ram_dout : rd_dat;
  assign hw_yield       = (starve == LIMIT);
  assign stat_code      = stat_q;
  assign stat_addr      = sw_addr;
  assign stat_datawords = 5'(datawords(N_DATA_BITS));
  assign starve_nxt     = (sw_cs && hw_cs) ? ((starve == LIMIT) ? starve : starve + 8'd1) : '0;

  always_comb begin
    state_nxt = state;
    stat_nxt  = stat_q;
    addr_nxt  = sw_addr;
    data_nxt  = sw_data;
    we_nxt    = sw_we;
    en_nxt    = enable;
    case (state)
      ST_IDLE: begin
        if (cmd_hit) begin
          case (cmnd_op_e'(cmnd_op))
            OP_NOP: ;
            OP_READ, OP_WRITE, OP_FILL: begin
              if (addr_bad) begin
                stat_nxt = STAT_ADDR_ERR;
              end else begin
                stat_nxt = STAT_BUSY;
                addr_nxt = cmnd_addr[N_ADDR_BITS-1:0];
                we_nxt   = (cmnd_op_e'(cmnd_op) != OP_READ);
                if (cmnd_op_e'(cmnd_op) != OP_READ) data_nxt = wr_dat;
                state_nxt = (cmnd_op_e'(cmnd_op) == OP_FILL) ? ST_FILL : ST_ACCESS;
              end
            end
            OP_ENABLE: begin
              en_nxt   = 1'b1;
              stat_nxt = STAT_OK;
            end
            OP_DISABLE: begin
              en_nxt   = 1'b0;
              stat_nxt = STAT_OK;
            end
            default: stat_nxt = STAT_OP_ERR;
          endcase
        end
      end
      ST_ACCESS: begin
        if (issue) begin
          if (sw_we) begin
            stat_nxt  = STAT_OK;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_RD_WAIT;
          end
        end
      end
      ST_RD_WAIT: begin
        if (capture) begin
          stat_nxt  = STAT_OK;
          state_nxt = ST_IDLE;
        end
      end
      ST_FILL: begin
        if (issue) begin
          if (sw_addr == LAST_ADDR) begin
            stat_nxt  = STAT_OK;
            state_nxt = ST_IDLE;
          end else begin
            addr_nxt = sw_addr + 1'b1;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Reset lands in FILL from address 0 so the init sweep restarts every time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_FILL;
      stat_q  <= STAT_BUSY;
      sw_addr <= '0;
      sw_data <= RESET_DATA;
      sw_we   <= 1'b1;
      enable  <= 1'b0;
      starve  <= '0;
      rd_dat  <= '0;
    end else begin
      state   <= state_nxt;
      stat_q  <= stat_nxt;
      sw_addr <= addr_nxt;
      sw_data <= data_nxt;
      sw_we   <= we_nxt;
      enable  <= en_nxt;
      starve  <= starve_nxt;
      if (capture) rd_dat <= ram_dout;
    end
  end

endmodule

// File: tb/tb_nx_ram_1rw_indirect_access_v3.sv
// Bench for nx_ram_1rw_indirect_access_v3 with a 16-entry, 3-cycle-latency RAM
// model and an expected-contents array for software read-back.
module tb_nx_ram_1rw_indirect_access_v3;

  localparam int DW  = 38;
  localparam int NE  = 16;
  localparam int AW  = 4;
  localparam int LAT = 3;
  localparam int SL  = 15;
  localparam logic [DW-1:0] RST_D = 38'h15_0000_C0DE;
  localparam logic [10:0]   CMD_A = 11'h1B8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_stb;
  logic [10:0]   reg_addr;
  logic [3:0]    cmnd_op;
  logic [AW:0]   cmnd_addr;
  logic [DW-1:0] wr_dat;
  logic [2:0]    stat_code;
  logic [4:0]    stat_datawords;
  logic [AW-1:0] stat_addr;
  logic [DW-1:0] rd_dat;
  logic          hw_cs, hw_we;
  logic [AW-1:0] hw_add;
  logic [DW-1:0] hw_bwe, hw_din, hw_dout;
  logic          hw_yield;
  logic          ram_cs, ram_we;
  logic [AW-1:0] ram_add;
  logic [DW-1:0] ram_bwe, ram_din, ram_dout;

  nx_ram_1rw_indirect_access_v3 #(
    .N_DATA_BITS (DW),
    .N_ENTRIES   (NE),
    .RD_LATENCY  (LAT),
    .STARVE_LIMIT(SL),
    .RESET_DATA  (RST_D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_stb(wr_stb), .reg_addr(reg_addr),
    .cmnd_op(cmnd_op), .cmnd_addr(cmnd_addr), .wr_dat(wr_dat),
    .stat_code(stat_code), .stat_datawords(stat_datawords),
    .stat_addr(stat_addr), .rd_dat(rd_dat),
    .hw_cs(hw_cs), .hw_we(hw_we), .hw_add(hw_add), .hw_bwe(hw_bwe),
    .hw_din(hw_din), .hw_dout(hw_dout), .hw_yield(hw_yield),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_add(ram_add),
    .ram_bwe(ram_bwe), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM macro model: bit-enabled writes, LAT-deep registered read path.
  logic [DW-1:0] mem [NE];
  logic [DW-1:0] pipe [LAT];
  always @(posedge clk) begin
    if (ram_cs && ram_we) mem[ram_add] <= (mem[ram_add] & ~ram_bwe) | (ram_din & ram_bwe);
    pipe[0] <= (ram_cs && !ram_we) ? mem[ram_add] : 38'h0B_AD0B_AD00;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ram_dout = pipe[LAT-1];

  int cyc = 0;
  int issue_at = -100;
  int cs_count = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_cs && !hw_cs && !ram_we) issue_at <= cyc + 1;
    if (ram_cs) cs_count <= cs_count + 1;
  end

  int n_checks = 0;
  int n_fail = 0;
  logic [DW-1:0] ref_mem [NE];
  logic [DW-1:0] exp_rd;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [AW:0] a, input logic [DW-1:0] d);
    wr_stb = 1'b1; reg_addr = CMD_A; cmnd_op = op; cmnd_addr = a; wr_dat = d;
    step();
    wr_stb = 1'b0; cmnd_op = 4'd0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (stat_code == 3'd1 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("wait_timeout", {61'd0, stat_code}, 64'd0);
  endtask

  task automatic sw_read(input int a);
    int n;
    do_cmd(4'd1, (AW+1)'(a), '0);
    wait_done(n);
    chk("rd_stat", {61'd0, stat_code}, 64'd0);
    chk("rd_data", {26'd0, rd_dat}, {26'd0, ref_mem[a]});
    chk("rd_latency", 64'(cyc - issue_at), 64'(LAT));
    chk("rd_stat_addr", {60'd0, stat_addr}, 64'(a));
    exp_rd = ref_mem[a];
  endtask

  task automatic sw_write(input int a, input logic [DW-1:0] d);
    int n;
    do_cmd(4'd2, (AW+1)'(a), d);
    wait_done(n);
    chk("wr_stat", {61'd0, stat_code}, 64'd0);
    chk("wr_cycles", 64'(n), 64'd1);
    ref_mem[a] = d;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [AW:0] addr;
    logic        wrong_reg;
    logic [2:0]  exp;
  } vec_t;
  vec_t vt [11];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, a;
    logic [DW-1:0] d, bwe;
    int c0;

    rst_n = 1'b0; wr_stb = 1'b0; reg_addr = '0; cmnd_op = '0; cmnd_addr = '0;
    wr_dat = '0; hw_cs = 1'b0; hw_we = 1'b0; hw_add = '0; hw_bwe = '0; hw_din = '0;
    exp_rd = '0;
    step(); step(); step();
    chk("rst_stat", {61'd0, stat_code}, 64'd1);
    chk("rst_stat_addr", {60'd0, stat_addr}, 64'd0);
    chk("rst_rd_dat", {26'd0, rd_dat}, 64'd0);
    chk("rst_yield", {63'd0, hw_yield}, 64'd0);
    chk("datawords", {59'd0, stat_datawords}, 64'd2);
    chk("rst_hw_dout", {26'd0, hw_dout}, 64'd0);

    // Auto-init sweep
    rst_n = 1'b1;
    wait_done(n);
    chk("init_busy_cycles", 64'(n), 64'(NE));
    for (int i = 0; i < NE; i++) ref_mem[i] = RST_D;
    sw_read(5);

    sw_write(3, 38'h2A_5A5A_5A5A);
    sw_read(3);

    // Status decode table: {op, addr, wrong register, expected status}
    vt[0]  = '{4'd1,  5'd16, 1'b0, 3'd2};
    vt[1]  = '{4'd0,  5'd0,  1'b0, 3'd2};
    vt[2]  = '{4'd9,  5'd3,  1'b0, 3'd3};
    vt[3]  = '{4'd2,  5'd31, 1'b0, 3'd2};
    vt[4]  = '{4'd15, 5'd0,  1'b0, 3'd3};
    vt[5]  = '{4'd5,  5'd17, 1'b0, 3'd2};
    vt[6]  = '{4'd4,  5'd0,  1'b0, 3'd0};
    vt[7]  = '{4'd6,  5'd0,  1'b0, 3'd3};
    vt[8]  = '{4'd3,  5'd0,  1'b0, 3'd0};
    vt[9]  = '{4'd1,  5'd2,  1'b1, 3'd0};
    vt[10] = '{4'd4,  5'd0,  1'b0, 3'd0};
    for (int i = 0; i < 11; i++) begin
      c0 = cs_count;
      wr_stb = 1'b1; reg_addr = vt[i].wrong_reg ? CMD_A + 11'd1 : CMD_A;
      cmnd_op = vt[i].op; cmnd_addr = vt[i].addr; wr_dat = 38'h3F_0F0F_0F0F;
      step();
      wr_stb = 1'b0; cmnd_op = 4'd0;
      step();
      chk($sformatf("vec%0d_stat", i), {61'd0, stat_code}, {61'd0, vt[i].exp});
      chk($sformatf("vec%0d_no_cs", i), 64'(cs_count - c0), 64'd0);
    end

    // Strobe while busy is ignored
    do_cmd(4'd1, 5'd3, '0);
    do_cmd(4'd2, 5'd7, 38'h11_2233_4455);
    chk("busy_strobe_stat", {61'd0, stat_code}, 64'd1);
    wait_done(n);
    chk("busy_rd_data", {26'd0, rd_dat}, {26'd0, ref_mem[3]});
    chk("busy_rd_latency", 64'(cyc - issue_at), 64'(LAT));
    sw_read(7);

    // Starvation: hw holds the RAM during a pending read
    hw_cs = 1'b1; hw_we = 1'b0; hw_add = 4'd1;
    do_cmd(4'd1, 5'd3, '0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (k == 14) chk("yield_k14", {63'd0, hw_yield}, 64'd0);
      if (k == 15) chk("yield_k15", {63'd0, hw_yield}, 64'd1);
      if (k == 40) chk("yield_k40", {63'd0, hw_yield}, 64'd1);
      if (k == 40) chk("starve_busy", {61'd0, stat_code}, 64'd1);
    end
    hw_cs = 1'b0;
    step();
    chk("yield_drop", {63'd0, hw_yield}, 64'd0);
    chk("starve_issue_cycle", 64'(issue_at), 64'(cyc));
    wait_done(n);
    chk("starve_rd_data", {26'd0, rd_dat}, {26'd0, ref_mem[3]});

    // Fill 12..15, then a hw-blocked fill of 14..15
    do_cmd(4'd5, 5'd12, 38'h1);
    wait_done(n);
    chk("fill_cycles", 64'(n), 64'd4);
    chk("fill_stat_addr", {60'd0, stat_addr}, 64'd15);
    for (int i = 12; i < NE; i++) ref_mem[i] = 38'h1;
    hw_cs = 1'b1; hw_we = 1'b0; hw_add = 4'd0;
    do_cmd(4'd5, 5'd14, 38'h22_CAFE_F00D);
    step(); step(); step();
    hw_cs = 1'b0;
    wait_done(n);
    chk("fill_blocked_cycles", 64'(n), 64'd2);
    ref_mem[14] = 38'h22_CAFE_F00D;
    ref_mem[15] = 38'h22_CAFE_F00D;
    for (int i = 0; i < NE; i++) sw_read(i);

    // ENABLE routes ram_dout to hw_dout; DISABLE routes rd_dat
    do_cmd(4'd3, 5'd0, '0);
    hw_cs = 1'b1; hw_we = 1'b0; hw_add = 4'd12;
    step();
    hw_cs = 1'b0;
    for (int i = 1; i < LAT; i++) step();
    chk("en_hw_dout", {26'd0, hw_dout}, {26'd0, ref_mem[12]});
    do_cmd(4'd4, 5'd0, '0);
    chk("dis_hw_dout", {26'd0, hw_dout}, {26'd0, exp_rd});

    // Randomised sw writes/reads and hw bit-enabled writes
    for (int it = 0; it < 40; it++) begin
      a = $urandom_range(0, NE - 1);
      d = DW'({$urandom(), $urandom()});
      case ($urandom_range(0, 2))
        0: sw_write(a, d);
        1: sw_read(a);
        default: begin
          bwe = DW'({$urandom(), $urandom()});
          hw_cs = 1'b1; hw_we = 1'b1; hw_add = AW'(a); hw_bwe = bwe; hw_din = d;
          step();
          hw_cs = 1'b0; hw_we = 1'b0;
          ref_mem[a] = (ref_mem[a] & ~bwe) | (d & bwe);
        end
      endcase
    end
    for (int i = 0; i < NE; i += 5) sw_read(i);

    // Asynchronous reset in the middle of a fill restarts the sweep
    do_cmd(4'd5, 5'd0, 38'h3F_FFFF_0000);
    step(); step(); step(); step(); step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_stat", {61'd0, stat_code}, 64'd1);
    chk("midrst_stat_addr", {60'd0, stat_addr}, 64'd0);
    chk("midrst_rd_dat", {26'd0, rd_dat}, 64'd0);
    step();
    rst_n = 1'b1;
    wait_done(n);
    chk("midrst_sweep_cycles", 64'(n), 64'(NE));
    for (int i = 0; i < NE; i++) ref_mem[i] = RST_D;
    sw_read(0);
    sw_read(5);
    sw_read(15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
